// File: rtl/adder_accumulator_if.sv
// Stream interface for adder_accumulator: operand input stream with a
// batch start strobe, and a result output stream carrying sum and overflow.
// master = operand source / result consumer side, slave = accumulator side.
interface adder_accumulator_if #(
   parameter int width = 4
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [width-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [width-1:0] out_sum;
   logic             out_ovf;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/adder_accumulator.sv
// adder_accumulator: sums a batch of `count` operands into a width-bit
// accumulator through a single ripple-carry adder, then offers the total and
// a sticky carry-out flag on a valid/ready output.
// Optional feature macro: SATURATE_EN -- when defined, any carry-out clamps
// the accumulator to all-ones instead of wrapping.
module adder_accumulator #(
   parameter int width = 4,
   parameter int count = 4
) (
   input  logic              clk,
   input  logic              reset,
   adder_accumulator_if.slave bus
);
   localparam int cnt_w = $clog2(count + 1);
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(count - 1);

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_accum = 2'd1,
      st_done  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [width-1:0] acc_reg, acc_next;
   logic [cnt_w-1:0] cnt_reg, cnt_next;
   logic             ovf_reg, ovf_next;

   logic             in_ready;
   logic             out_valid;

   // Ripple-carry adder: a = accumulator, b = operand, carry-in tied low.
   logic [width-1:0] sum;
   logic [width:0]   carry;
   logic             cout;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < width; gi++) begin : g_rca
         assign sum[gi]       = acc_reg[gi] ^ bus.in_data[gi] ^ carry[gi];
         assign carry[gi + 1] = (acc_reg[gi] & bus.in_data[gi])
                              | (carry[gi] & (acc_reg[gi] ^ bus.in_data[gi]));
      end
   endgenerate

   assign cout = carry[width];

   // Next-state, datapath update and handshake outputs, decoded from state.
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         st_idle: begin
            // Operands offered while idle are ignored; only start matters.
            if (bus.start) begin
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
               state_next = st_accum;
            end
         end
         st_accum: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
`ifdef SATURATE_EN
               // Clamp on carry; an all-ones accumulator stays all-ones since
               // any nonzero operand carries out and a zero operand adds nothing.
               acc_next = cout ? {width{1'b1}} : sum;
`else
               acc_next = sum;
`endif
               ovf_next = ovf_reg | cout;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == last_cnt) begin
                  state_next = st_done;
               end
            end
         end
         st_done: begin
            // Result held in registers until the consumer takes it; a start
            // seen here is dropped, a new batch needs start while idle.
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = st_idle;
            end
         end
         default: begin
            state_next = st_idle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any partial batch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= st_idle;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
      end
   end

   // Outputs come straight from registers or state decode, never from in_data.
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = acc_reg;
   assign bus.out_ovf   = ovf_reg;
endmodule

// File: tb/tb_adder_accumulator.sv
// Directed testbench for adder_accumulator (width=4, count=4).
module tb_adder_accumulator;
   localparam int width = 4;
   localparam int count = 4;

   logic clk = 1'b0;
   logic reset;

   adder_accumulator_if #(.width(width)) bus ();

   adder_accumulator #(.width(width), .count(count)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] ops [4];
      logic [3:0] sum_wrap;
      logic [3:0] sum_sat;
      logic       ovf;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end else begin
         $display("ok   %s value=%0d t=%0t", name, act, $time);
      end
   endtask

   function automatic logic [3:0] pick(input logic [3:0] w, input logic [3:0] s);
`ifdef SATURATE_EN
      return s;
`else
      return w;
`endif
   endfunction

   // Present one operand after `gap` idle cycles; returns #1 after the accept edge.
   task automatic feed(input logic [3:0] op, input int gap);
      int n;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
         check("gap_in_ready", bus.in_ready, 1);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = op;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) check("accept_wait_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   // Full batch: start, four operands, optional output backpressure, handshake
   // with a simultaneous (ignored) start, then confirm no extra batch began.
   task automatic run_batch(input string tag, input logic [3:0] ops [4], input int gap,
                            input int hold, input logic [3:0] exp_sum, input logic exp_ovf,
                            input bit start_in_accum);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_in_ready_accum"}, bus.in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         if (start_in_accum && i == 1) bus.start = 1'b1;
         feed(ops[i], gap);
         if (i < 3) check({tag, "_out_valid_early"}, bus.out_valid, 0);
      end
      check({tag, "_out_valid"}, bus.out_valid, 1);
      check({tag, "_in_ready_done"}, bus.in_ready, 0);
      check({tag, "_sum"}, bus.out_sum, exp_sum);
      check({tag, "_ovf"}, bus.out_ovf, exp_ovf);
      repeat (hold) begin
         if (hold > 0) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_sum"}, bus.out_sum, exp_sum);
         check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check({tag, "_idle_valid"}, bus.out_valid, 0);
      check({tag, "_idle_in_ready"}, bus.in_ready, 0);
      @(posedge clk); #1;
      check({tag, "_no_extra_batch"}, bus.in_ready, 0);
   endtask

   initial begin
      logic [3:0] ones [4];
      logic [3:0] twos [4];

      vecs[0].ops = '{4'd1, 4'd2, 4'd3, 4'd4};   vecs[0].sum_wrap = 4'd10; vecs[0].sum_sat = 4'd10; vecs[0].ovf = 1'b0;
      vecs[1].ops = '{4'd15, 4'd1, 4'd0, 4'd0};  vecs[1].sum_wrap = 4'd0;  vecs[1].sum_sat = 4'd15; vecs[1].ovf = 1'b1;
      vecs[2].ops = '{4'd5, 4'd5, 4'd5, 4'd0};   vecs[2].sum_wrap = 4'd15; vecs[2].sum_sat = 4'd15; vecs[2].ovf = 1'b0;
      vecs[3].ops = '{4'd8, 4'd8, 4'd0, 4'd0};   vecs[3].sum_wrap = 4'd0;  vecs[3].sum_sat = 4'd15; vecs[3].ovf = 1'b1;
      vecs[4].ops = '{4'd15, 4'd15, 4'd15, 4'd15}; vecs[4].sum_wrap = 4'd12; vecs[4].sum_sat = 4'd15; vecs[4].ovf = 1'b1;
      vecs[5].ops = '{4'd0, 4'd0, 4'd0, 4'd0};   vecs[5].sum_wrap = 4'd0;  vecs[5].sum_sat = 4'd0;  vecs[5].ovf = 1'b0;
      vecs[6].ops = '{4'd9, 4'd0, 4'd7, 4'd1};   vecs[6].sum_wrap = 4'd1;  vecs[6].sum_sat = 4'd15; vecs[6].ovf = 1'b1;
      ones = '{4'd1, 4'd1, 4'd1, 4'd1};
      twos = '{4'd2, 4'd2, 4'd2, 4'd2};

      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_in_ready", bus.in_ready, 0);
      check("reset_out_sum", bus.out_sum, 0);
      check("reset_out_ovf", bus.out_ovf, 0);
      #11 reset = 1'b0;

      // Operands offered in IDLE without start are ignored.
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd7;
      repeat (2) begin
         @(posedge clk); #1;
         check("idle_ignores_in_valid", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;

      // Table-driven batches, back-to-back operands, immediate out_ready.
      for (int v = 0; v < 7; v++) begin
         run_batch($sformatf("vec%0d", v), vecs[v].ops, 0, 0,
                   pick(vecs[v].sum_wrap, vecs[v].sum_sat), vecs[v].ovf, 1'b0);
      end

      // Operand gaps plus three cycles of output backpressure (start pulsed there).
      run_batch("gaps", twos, 2, 3, 4'd8, 1'b0, 1'b0);

      // Asynchronous reset mid-batch after two accepted operands.
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      feed(4'd15, 0);
      feed(4'd2, 0);
      check("pre_reset_sum", bus.out_sum, pick(4'd1, 4'd15));
      check("pre_reset_ovf", bus.out_ovf, 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_out_valid", bus.out_valid, 0);
      check("async_reset_in_ready", bus.in_ready, 0);
      check("async_reset_out_sum", bus.out_sum, 0);
      check("async_reset_out_ovf", bus.out_ovf, 0);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      check("reset_no_resume", bus.in_ready, 0);

      // Fresh batch after reset, with start pulsed during ACCUM and DONE.
      run_batch("after_reset", ones, 0, 1, 4'd4, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
